lut_config_loader: RTL and testbench
====================================

Name: lut_config_loader

Overview:
- Upstream configuration stage for the LUT-based fabric (4-bit adder and similar).
- Accepts a framed 32-bit configuration word stream over a valid/ready handshake, checks a sync word, and assembles one 33-bit frame per LUT: 32-bit truth table plus 1 mode bit.
- Writes each frame into LUT storage with a one-hot write strobe, so LUT mem[32:0] is loaded through hardware rather than by direct assignment.

Parameters:
- NUM_LUT, 6, number of LUT slots loaded per stream (one frame each, slot 0 first).
- SYNC_WORD, 32'hC0F16A5E, required first word of every stream.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a new load (honoured only when not busy).
- in_word  input  32  configuration stream word.
- in_valid  input  1  in_word is valid this cycle.
- in_ready  output  1  loader accepts in_word this cycle (handshake = in_valid & in_ready).
- cfg_data  output  33  frame to LUT: [31:0] truth table, [32] mode bit.
- cfg_we  output  NUM_LUT  one-hot write strobe; bit i writes cfg_data into LUT i.
- busy  output  1  load in progress.
- done  output  1  sticky; last stream loaded successfully.
- error  output  1  sticky; last stream aborted.

Behaviour:
- Reset (async assert, sync release) values: state IDLE; in_ready=0, cfg_data=0, cfg_we=0, busy=0, done=0, error=0; slot index=0.
- States: IDLE, SYNC, LOW, HIGH, WRITE, CHECK (only with the optional feature), DONE, ERROR.
- IDLE/DONE/ERROR: in_ready=0. On start: clear done and error, set slot index to 0, set busy=1, go to SYNC. start is ignored in SYNC/LOW/HIGH/WRITE/CHECK.
- SYNC: in_ready=1. On handshake: in_word==SYNC_WORD -> LOW; any other value -> ERROR (error=1, busy=0).
- LOW: in_ready=1. On handshake: latch in_word as truth table -> HIGH.
- HIGH: in_ready=1. On handshake: mode bit = in_word[0]; in_word[31:1] is ignored -> WRITE.
- WRITE: in_ready=0. Exactly one cycle. cfg_we[index]=1 and cfg_data={mode, truth table}. cfg_data is registered and holds its value until the next WRITE.
- After WRITE: if index==NUM_LUT-1 go to CHECK (feature on) or DONE (feature off); otherwise increment index and go to LOW.
- Latency: the cfg_we pulse is registered and appears the cycle after the HIGH-word handshake. Minimum stream time is 1 + 3*NUM_LUT cycles (SYNC word, then 2 words plus 1 write cycle per slot).
- DONE: done=1, busy=0. done holds until the next start or reset.
- in_valid low stalls indefinitely in any accepting state; there is no timeout.
- in_word is sampled only on a handshake.
- cfg_we is never multi-hot and is 0 outside WRITE.
- Reset mid-stream: abort immediately. Slots already written keep their contents; no further strobes are issued.
- start and in_valid in the same cycle in IDLE: start is taken; the word is not consumed (in_ready=0).

Optional Feature:
- Macro: LUT_CONFIG_CHECKSUM_EN.
- Defined:
  - After the last WRITE, enter CHECK (in_ready=1) and accept one trailer word.
  - Trailer must equal the XOR of all 2*NUM_LUT payload words (sync word excluded).
  - Match -> DONE. Mismatch -> ERROR.
  - Frames already written are not rolled back.
- Undefined: CHECK state does not exist; the stream ends after the last payload word; no trailer is consumed.

Test Plan:
- Reset: hold reset_n=0 with in_valid=1 -> all outputs 0, in_ready=0. Release, pulse start -> busy=1, in_ready=1 the next cycle.
- Adder stream, NUM_LUT=6:
  - Stimulus: start; SYNC_WORD; then pairs {32'h96696996, 1}, {32'h96696996, 1}, {32'hE8E8E8E8, 0}, {32'hE8E8E8E8, 0}, {32'hFF00FF00, 1}, {32'hFF00FF00, 1}, all with in_valid=1.
  - Response: cfg_we sequence 000001, 000010, ... 100000, one cycle each, with matching cfg_data (e.g. 33'h196696996 for slot 0). done=1 after 19 cycles.
- Bad sync: start; first word 32'hDEADBEEF -> error=1, busy=0, cfg_we never asserted. A fresh start clears error.
- Stall: drop in_valid for 5 cycles between the LOW and HIGH words of slot 2 -> no cfg_we during the stall; slot 2 is written one cycle after the HIGH handshake; final result matches the unstalled run.
- Reset mid-load: assert reset_n=0 after slot 3 is written -> outputs return to reset values at once. A new start plus a full stream completes with done=1.
- With LUT_CONFIG_CHECKSUM_EN:
  - Correct XOR trailer -> done=1.
  - Trailer with bit 0 flipped -> error=1, done=0. All 6 cfg_we pulses still observed.

Source files
------------

// File: rtl/lut_config_loader.sv
// Frames a sync-led 32-bit word stream into 33-bit LUT frames and writes them with a one-hot strobe.
// Optional XOR trailer check over all payload words is enabled by defining LUT_CONFIG_CHECKSUM_EN.
module lut_config_loader #(
  parameter int          NUM_LUT   = 6,
  parameter logic [31:0] SYNC_WORD = 32'hC0F16A5E
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [31:0]        in_word,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [32:0]        cfg_data,
  output logic [NUM_LUT-1:0] cfg_we,
  output logic               busy,
  output logic               done,
  output logic               error
);

  localparam int            IW   = (NUM_LUT > 1) ? $clog2(NUM_LUT) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_LUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SYNC  = 3'd1,
    S_LOW   = 3'd2,
    S_HIGH  = 3'd3,
    S_WRITE = 3'd4,
`ifdef LUT_CONFIG_CHECKSUM_EN
    S_CHECK = 3'd5,
`endif
    S_DONE  = 3'd6,
    S_ERROR = 3'd7
  } state_t;

  state_t             state, state_nxt;
  logic [IW-1:0]      idx;
  logic [31:0]        tt;
  logic               take;
  logic               last;
  logic               sync_ok;
  logic [NUM_LUT-1:0] we_onehot;

  assign take      = in_valid & in_ready;
  assign last      = (idx == LAST);
  assign sync_ok   = (in_word == SYNC_WORD);
  assign we_onehot = NUM_LUT'(1) << idx;

`ifdef LUT_CONFIG_CHECKSUM_EN
  logic [31:0] xsum;
  logic        trl_ok;
  assign trl_ok = (in_word == xsum);
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) state_nxt = S_SYNC;
      end
      S_SYNC: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = sync_ok ? S_LOW : S_ERROR;
      end
      S_LOW: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_HIGH;
      end
      S_HIGH: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_WRITE;
      end
      S_WRITE: begin
`ifdef LUT_CONFIG_CHECKSUM_EN
        state_nxt = last ? S_CHECK : S_LOW;
`else
        state_nxt = last ? S_DONE : S_LOW;
`endif
      end
`ifdef LUT_CONFIG_CHECKSUM_EN
      S_CHECK: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = trl_ok ? S_DONE : S_ERROR;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // The strobe is registered on the HIGH handshake so it lines up with the WRITE cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idx      <= '0;
      tt       <= '0;
      cfg_data <= '0;
      cfg_we   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
`ifdef LUT_CONFIG_CHECKSUM_EN
      xsum     <= '0;
`endif
    end else begin
      cfg_we <= '0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            idx   <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
            error <= 1'b0;
`ifdef LUT_CONFIG_CHECKSUM_EN
            xsum  <= '0;
`endif
          end
        end
        S_SYNC: begin
          if (take && !sync_ok) begin
            error <= 1'b1;
            busy  <= 1'b0;
          end
        end
        S_LOW: begin
          if (take) begin
            tt <= in_word;
`ifdef LUT_CONFIG_CHECKSUM_EN
            xsum <= xsum ^ in_word;
`endif
          end
        end
        S_HIGH: begin
          if (take) begin
            cfg_data <= {in_word[0], tt};
            cfg_we   <= we_onehot;
`ifdef LUT_CONFIG_CHECKSUM_EN
            xsum     <= xsum ^ in_word;
`endif
          end
        end
        S_WRITE: begin
          if (!last) begin
            idx <= idx + 1'b1;
          end else begin
`ifndef LUT_CONFIG_CHECKSUM_EN
            done <= 1'b1;
            busy <= 1'b0;
`endif
          end
        end
`ifdef LUT_CONFIG_CHECKSUM_EN
        S_CHECK: begin
          if (take) begin
            done  <= trl_ok;
            error <= !trl_ok;
            busy  <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lut_config_loader.sv
// Bench for lut_config_loader: adder table, bad sync, stall, mid-load reset, and random streams vs. a stream-level model.
module tb_lut_config_loader;

  localparam int          N    = 6;
  localparam logic [31:0] SYNC = 32'hC0F16A5E;
`ifdef LUT_CONFIG_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n, start, in_valid, in_ready, busy, done, error;
  logic [31:0]  in_word;
  logic [32:0]  cfg_data;
  logic [N-1:0] cfg_we;

  always #5 clk = ~clk;

  lut_config_loader #(.NUM_LUT(N), .SYNC_WORD(SYNC)) dut (
    .clock(clk), .reset_n(reset_n), .start(start), .in_word(in_word),
    .in_valid(in_valid), .in_ready(in_ready), .cfg_data(cfg_data),
    .cfg_we(cfg_we), .busy(busy), .done(done), .error(error)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [N-1:0] we;
    logic [32:0]  data;
    int           c;
  } wr_t;
  wr_t obs[$];
  int  multihot = 0;

  always @(negedge clk) begin
    if (cfg_we != '0) begin
      wr_t w;
      w.we = cfg_we; w.data = cfg_data; w.c = cyc;
      obs.push_back(w);
      if ($countones(cfg_we) != 1) multihot++;
    end
  end

  typedef struct {
    logic [31:0]  tt;
    logic         mode;
    logic [32:0]  exp_data;
    logic [N-1:0] exp_we;
  } vec_t;
  vec_t tbl[N];

  logic [31:0] s_sync;
  logic [31:0] s_tt[N], s_hi[N];
  int          s_stall[N], s_stall_lo[N], hs_hi[N];
  bit          s_flip;
  int          start_cyc, idle_cyc;
  int          n_chk = 0, n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] xor_payload();
    logic [31:0] x = '0;
    for (int i = 0; i < N; i++) x = x ^ s_tt[i] ^ s_hi[i];
    return x;
  endfunction

  task automatic send_word(input logic [31:0] w, input int stall, output int hsc);
    in_valid = 1'b0;
    if (stall > 0) begin
      repeat (stall) @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_word  = w;
    hsc      = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (in_ready) begin
        hsc = cyc;
        break;
      end
    end
    n_chk++;
    if (hsc < 0) begin
      n_err++;
      $display("FAIL handshake_timeout: got no in_ready, expected one within 40 cycles");
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_word  = $urandom;
    end
  endtask

  task automatic pulse_start();
    start     = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    idle_cyc = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!busy) begin
        idle_cyc = cyc;
        break;
      end
    end
    n_chk++;
    if (idle_cyc < 0) begin
      n_err++;
      $display("FAIL idle_timeout: busy still 1, expected 0 within 40 cycles");
    end
  endtask

  task automatic feed_slots(input int first, input int upto);
    int h;
    for (int i = first; i < upto; i++) begin
      send_word(s_tt[i], s_stall_lo[i], h);
      send_word(s_hi[i], s_stall[i], h);
      hs_hi[i] = h;
    end
  endtask

  task automatic feed();
    int h;
    send_word(s_sync, 0, h);
    if (s_sync == SYNC) begin
      feed_slots(0, N);
`ifdef LUT_CONFIG_CHECKSUM_EN
      send_word(xor_payload() ^ {31'b0, s_flip}, 0, h);
`endif
    end
    wait_idle();
  endtask

  task automatic run_stream();
    obs.delete();
    pulse_start();
    feed();
  endtask

  // Stream-level model: a good sync yields one frame per slot in order; the trailer only matters when checked.
  task automatic check_stream(input string tag);
    bit ok, exp_done;
    int exp_n;
    ok       = (s_sync == SYNC);
    exp_done = ok && !(CK && s_flip);
    exp_n    = ok ? N : 0;
    chk({tag, "_nwr"}, obs.size(), exp_n);
    for (int i = 0; i < exp_n && i < obs.size(); i++) begin
      logic [N-1:0] ew;
      ew = N'(1) << i;
      chk($sformatf("%s_we%0d", tag, i), obs[i].we, ew);
      chk($sformatf("%s_data%0d", tag, i), obs[i].data, {s_hi[i][0], s_tt[i]});
    end
    chk({tag, "_done"}, done, exp_done);
    chk({tag, "_error"}, error, !exp_done);
    chk({tag, "_we_idle"}, cfg_we, 0);
  endtask

  task automatic load_table();
    s_sync = SYNC;
    s_flip = 1'b0;
    for (int i = 0; i < N; i++) begin
      s_tt[i]       = tbl[i].tt;
      s_hi[i]       = {31'b0, tbl[i].mode};
      s_stall[i]    = 0;
      s_stall_lo[i] = 0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int h;
    tbl[0] = '{32'h96696996, 1'b1, 33'h1_96696996, 6'b000001};
    tbl[1] = '{32'h96696996, 1'b1, 33'h1_96696996, 6'b000010};
    tbl[2] = '{32'hE8E8E8E8, 1'b0, 33'h0_E8E8E8E8, 6'b000100};
    tbl[3] = '{32'hE8E8E8E8, 1'b0, 33'h0_E8E8E8E8, 6'b001000};
    tbl[4] = '{32'hFF00FF00, 1'b1, 33'h1_FF00FF00, 6'b010000};
    tbl[5] = '{32'hFF00FF00, 1'b1, 33'h1_FF00FF00, 6'b100000};

    reset_n = 1'b0; start = 1'b0; in_valid = 1'b1; in_word = SYNC;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {in_ready, cfg_we, cfg_data, busy, done, error}, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Adder table, with start and in_valid raised together in IDLE.
    load_table();
    obs.delete();
    start = 1'b1;
    @(negedge clk);
    start_cyc = cyc;
    chk("idle_no_ready", in_ready, 0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_ready", in_ready, 1);
    feed();
    chk("adder_nwr", obs.size(), N);
    for (int i = 0; i < N && i < obs.size(); i++) begin
      chk($sformatf("adder_we%0d", i), obs[i].we, tbl[i].exp_we);
      chk($sformatf("adder_data%0d", i), obs[i].data, tbl[i].exp_data);
    end
    chk("adder_done", done, 1);
    chk("adder_error", error, 0);
    chk("adder_cycles", idle_cyc - start_cyc - 1, 1 + 3 * N + int'(CK));
    chk("hold_data", cfg_data, tbl[N-1].exp_data);

    // Bad sync, then a fresh start clears error.
    s_sync = 32'hDEADBEEF;
    run_stream();
    check_stream("badsync");
    chk("badsync_busy", busy, 0);
    obs.delete();
    pulse_start();
    chk("restart_clr_err", error, 0);
    chk("restart_busy", busy, 1);
    s_sync = SYNC;
    feed();
    check_stream("restart");

    // Stall between LOW and HIGH words of slot 2.
    load_table();
    s_stall[2] = 5;
    run_stream();
    check_stream("stall");
    if (obs.size() == N)
      for (int i = 0; i < N; i++)
        chk($sformatf("stall_lat%0d", i), obs[i].c, hs_hi[i] + 1);

    // Trailer with bit 0 flipped: only a checked build rejects it.
    load_table();
    s_flip = 1'b1;
    run_stream();
    check_stream("flip");

    // Reset right after slot 3 is written.
    load_table();
    obs.delete();
    pulse_start();
    send_word(SYNC, 0, h);
    feed_slots(0, 4);
    #2;
    chk("mid_we3", cfg_we, 6'b001000);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_outputs", {in_ready, cfg_we, cfg_data, busy, done, error}, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_no_more_we", obs.size(), 3);
    run_stream();
    check_stream("after_rst");

    // Random streams.
    for (int r = 0; r < 12; r++) begin
      s_sync = ($urandom_range(0, 4) == 0) ? $urandom : SYNC;
      s_flip = $urandom_range(0, 1) == 1;
      for (int i = 0; i < N; i++) begin
        s_tt[i]       = $urandom;
        s_hi[i]       = $urandom;
        s_stall[i]    = $urandom_range(0, 2);
        s_stall_lo[i] = $urandom_range(0, 2);
      end
      run_stream();
      check_stream($sformatf("rnd%0d", r));
    end

    chk("onehot", multihot, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
